// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: pops one word at a time into tx_data and
// handshakes with the transmitter's busy flag, re-requesting if busy never rises.
module uart_tx_feeder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      clr_overflow,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      tx_enable,
  output logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      tx_busy,
  output logic                      idle
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [7:0]  TmoLast    = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitBusy, StWaitDone} state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_q;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q;
  logic [7:0]              tmo_q;
  logic                    pop;
  logic                    push;
  logic                    drop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_WIDTH'(DEPTH));
  // A new word is taken only from IDLE or when the current frame has finished.
  assign pop       = !empty && ((state_q == StIdle) || ((state_q == StWaitDone) && !tx_busy));
  assign push      = wr_en && (!full || pop);
  assign drop      = wr_en && !push;
  assign tx_enable = (state_q == StReq) && !tx_busy;
  assign idle      = (state_q == StIdle) && empty;

  // Storage carries no reset; validity is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      tmo_q    <= '0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        tx_data  <= mem[rd_ptr_q];
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!empty) state_q <= StReq;
        end
        StReq: begin
          if (!tx_busy) begin
            state_q <= StWaitBusy;
            tmo_q   <= '0;
          end
        end
        StWaitBusy: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end else if (tmo_q == TmoLast) begin
            state_q <= StReq;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!tx_busy) state_q <= empty ? StIdle : StReq;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
